fir_mac_sched: RTL and testbench

- Time-multiplexed 4-tap FIR engine with a controller around a single shared multiplier.
- Accepts samples over a valid/ready handshake and sequences one multiply-accumulate per cycle across the taps.
- Presents each result over a valid/ready handshake.
- Manages a shadow/active coefficient bank, so coefficients can be rewritten at runtime without corrupting an in-flight computation.
- Sits between the sample source and the downstream consumer in the filter datapath.

---
 rtl/fir_mac_sched_if.sv | 42 ++++
 rtl/fir_mac_sched.sv | 118 +++++++++++
 tb/tb_fir_mac_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sched_if.sv
// Sample-in / result-out handshakes plus shadow coefficient write port for fir_mac_sched.
// With FIR_SAT_EN defined the result side also carries sat_flag.
interface fir_mac_sched_if #(
  parameter int DW   = 8,
  parameter int CW   = 3,
  parameter int TAPS = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DW-1:0]           Din;
  logic                    out_valid;
  logic                    out_ready;
  logic [DW-1:0]           Dout;
  logic                    coef_we;
  logic [$clog2(TAPS)-1:0] coef_addr;
  logic [CW-1:0]           coef_wdata;
  logic                    coef_commit;
  logic                    busy;
`ifdef FIR_SAT_EN
  logic                    sat_flag;

  modport master (
    output in_valid, Din, out_ready, coef_we, coef_addr, coef_wdata, coef_commit,
    input  in_ready, out_valid, Dout, busy, sat_flag
  );

  modport slave (
    input  in_valid, Din, out_ready, coef_we, coef_addr, coef_wdata, coef_commit,
    output in_ready, out_valid, Dout, busy, sat_flag
  );
`else
  modport master (
    output in_valid, Din, out_ready, coef_we, coef_addr, coef_wdata, coef_commit,
    input  in_ready, out_valid, Dout, busy
  );

  modport slave (
    input  in_valid, Din, out_ready, coef_we, coef_addr, coef_wdata, coef_commit,
    output in_ready, out_valid, Dout, busy
  );
`endif
endinterface

// File: rtl/fir_mac_sched.sv
// TAPS-tap FIR on one shared multiplier: one MAC per cycle, result TAPS edges after accept, held until out_ready.
// Shadow/active coefficient banks swap only on an accept edge; FIR_SAT_EN selects unsigned saturation plus sat_flag.
module fir_mac_sched #(
  parameter int DW   = 8,
  parameter int CW   = 3,
  parameter int TAPS = 4,
  parameter int AW   = DW + CW + $clog2(TAPS)
) (
  input logic           CLK,
  input logic           reset,
  fir_mac_sched_if.slave bus
);

  localparam int IW = $clog2(TAPS);
  localparam logic [IW-1:0] LAST = IW'(TAPS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [AW-1:0] acc;
  logic [DW-1:0] dl     [TAPS];
  logic [CW-1:0] shadow [TAPS];
  logic [CW-1:0] active [TAPS];
  logic          pending;
  logic [DW-1:0] dout_q;
  logic          ov_q;

  logic             accept;
  logic [DW+CW-1:0] prod;
  logic [AW-1:0]    sum;

  assign accept = bus.in_valid && (state == ST_IDLE);
  assign prod   = {{CW{1'b0}}, dl[idx]} * {{DW{1'b0}}, active[idx]};
  assign sum    = acc + AW'(prod);

`ifdef FIR_SAT_EN
  logic sat_q;
  logic over;
  assign over         = |sum[AW-1:DW];
  assign bus.sat_flag = sat_q;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      acc     <= '0;
      pending <= 1'b0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dl[i]     <= '0;
        shadow[i] <= '0;
        active[i] <= '0;
      end
`ifdef FIR_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      if (bus.coef_we)
        shadow[bus.coef_addr] <= bus.coef_wdata;

      // A commit on the accept edge survives for the following sample.
      if (bus.coef_commit)
        pending <= 1'b1;
      else if (accept && pending)
        pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            for (int i = 0; i < TAPS - 1; i++)
              dl[i] <= dl[i+1];
            dl[TAPS-1] <= bus.Din;
            acc        <= '0;
            idx        <= '0;
            state      <= ST_MAC;
            if (pending)
              active <= shadow;
          end
        end
        ST_MAC: begin
          acc <= sum;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
`ifdef FIR_SAT_EN
            dout_q <= over ? {DW{1'b1}} : sum[DW-1:0];
            sat_q  <= over;
`else
            dout_q <= sum[DW-1:0];
`endif
            ov_q  <= 1'b1;
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            ov_q  <= 1'b0;
            state <= ST_IDLE;
`ifdef FIR_SAT_EN
            sat_q <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = ov_q;
  assign bus.Dout      = dout_q;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: reference model fills a scoreboard queue at each accept, results checked as they appear.
module tb_fir_mac_sched;

  localparam int DW   = 8;
  localparam int CW   = 3;
  localparam int TAPS = 4;

  logic CLK = 1'b0;
  logic reset;

  fir_mac_sched_if #(.DW(DW), .CW(CW), .TAPS(TAPS)) bus ();

  fir_mac_sched #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rises = 0;
  int acc_cyc;
  int rises_before;
  logic prev_ov = 1'b0;
  logic [DW-1:0] last_dout;
  logic [DW-1:0] held_exp;

  int m_dl [TAPS];
  int m_sh [TAPS];
  int m_act[TAPS];
  int m_pend;

  logic [DW:0] exp_q[$];

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (bus.out_valid === 1'b1 && prev_ov !== 1'b1) rises++;
    prev_ov = bus.out_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW:0] model_out();
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += m_dl[i] * m_act[i];
`ifdef FIR_SAT_EN
    if (s > 255) return {1'b1, 8'hFF};
    return {1'b0, 8'(s)};
`else
    return {1'b0, 8'(s)};
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_dl[i] = 0; m_sh[i] = 0; m_act[i] = 0;
    end
    m_pend = 0;
  endtask

  task automatic write_coef(input int a, input int v);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 2'(a);
    bus.coef_wdata = 3'(v);
    tick();
    bus.coef_we = 1'b0;
    m_sh[a] = v;
  endtask

  task automatic commit();
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    m_pend = 1;
  endtask

  task automatic accept(input int sample);
    bus.Din      = 8'(sample);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && bus.in_ready !== 1'b1; k++) tick();
    chk("in_ready_timeout", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    if (m_pend != 0) begin
      for (int i = 0; i < TAPS; i++) m_act[i] = m_sh[i];
      m_pend = 0;
    end
    for (int i = 0; i < TAPS - 1; i++) m_dl[i] = m_dl[i+1];
    m_dl[TAPS-1] = sample;
    exp_q.push_back(model_out());
    acc_cyc = cyc;
  endtask

  task automatic wait_result(input bit check_lat);
    logic [DW:0] e;
    for (int k = 0; k < 50 && bus.out_valid !== 1'b1; k++) tick();
    chk("out_valid_timeout", 32'(bus.out_valid), 1);
    if (check_lat) chk("latency", cyc - acc_cyc, TAPS);
    e = exp_q.pop_front();
    chk("Dout", 32'(bus.Dout), 32'(e[DW-1:0]));
`ifdef FIR_SAT_EN
    chk("sat_flag", 32'(bus.sat_flag), 32'(e[DW]));
`endif
    last_dout    = bus.Dout;
    bus.out_ready = 1'b1;
    tick();
    chk("back_to_idle", 32'(bus.in_ready), 1);
  endtask

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.Din         = '0;
    bus.out_ready   = 1'b1;
    bus.coef_we     = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_wdata  = '0;
    bus.coef_commit = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    // reset state and idle behaviour
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_Dout", 32'(bus.Dout), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    repeat (10) tick();
    chk("idle_no_output", rises, 0);
    chk("idle_busy", 32'(bus.busy), 0);

    // impulse response
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    commit();
    accept(1);
    chk("busy_in_mac", 32'(bus.busy), 1);
    chk("in_ready_in_mac", 32'(bus.in_ready), 0);
    wait_result(1);
    chk("impulse0", 32'(last_dout), 4);
    accept(0); wait_result(1); chk("impulse1", 32'(last_dout), 3);
    accept(0); wait_result(1); chk("impulse2", 32'(last_dout), 2);
    accept(0); wait_result(1); chk("impulse3", 32'(last_dout), 1);

    // overflow / saturation
    for (int i = 0; i < TAPS; i++) write_coef(i, 7);
    commit();
    for (int n = 0; n < 4; n++) begin
      accept(255);
      wait_result(1);
    end
`ifdef FIR_SAT_EN
    chk("overflow_sat", 32'(last_dout), 32'hFF);
`else
    chk("overflow_wrap", 32'(last_dout), 32'hE4);
`endif

    // backpressure: OUT held, concurrent in_valid ignored
    bus.out_ready = 1'b0;
    accept(77);
    for (int k = 0; k < 50 && bus.out_valid !== 1'b1; k++) tick();
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    held_exp = exp_q[0][DW-1:0];
    bus.Din      = 8'h99;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.out_valid), 1);
      chk("bp_hold_Dout", 32'(bus.Dout), 32'(held_exp));
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    wait_result(0);
    chk("bp_idle_out_valid", 32'(bus.out_valid), 0);
    accept(0);
    wait_result(1);

    // coefficient swap during an in-flight computation
    for (int i = 0; i < TAPS; i++) write_coef(i, 1);
    commit();
    bus.out_ready = 1'b0;
    accept(10);
    for (int i = 0; i < TAPS; i++) write_coef(i, 2);
    commit();
    wait_result(0);
    accept(10);
    wait_result(1);

    // reset in the middle of MAC aborts the computation
    write_coef(0, 3);
    commit();
    accept(9);
    tick();
    tick();
    rises_before = rises;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    void'(exp_q.pop_back());
    repeat (10) tick();
    chk("abort_no_valid", rises, rises_before);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    write_coef(3, 1);
    commit();
    accept(5);
    wait_result(1);
    chk("after_abort", 32'(last_dout), 5);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
